// File: rtl/pipe_share_arbiter_if.sv
// +------------------------------------------------------------------+
// | pipe_share_arbiter_if : requester/unit bus of pipe_share_arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface pipe_share_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int RESULT_WIDTH = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         unit_in;
  logic                     unit_in_valid;
  logic [RESULT_WIDTH-1:0]  unit_out;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [RESULT_WIDTH-1:0]  resp_data;
  logic                     busy;

  // master: requesters plus the shared unit; slave: the arbiter itself
  modport master (
    output req_valid, req_data, unit_out,
    input  req_ready, unit_in, unit_in_valid, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_data, unit_out,
    output req_ready, unit_in, unit_in_valid, resp_valid, resp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/pipe_share_arbiter.sv
// +------------------------------------------------------------------+
// | pipe_share_arbiter : round-robin share of one fixed-latency unit |
// | Option: PIPE_ARB_FIXED_PRIO_EN selects fixed lowest-index prio.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int RESULT_WIDTH = 32,
  parameter int LATENCY      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_share_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t               ptr_q;
  idx_t               ptr_d;
  logic [WIDTH-1:0]   unit_in_q;
  logic               unit_in_valid_q;
  idx_t               issue_idx_q;
  logic [LATENCY-1:0] tag_valid_q;
  idx_t               tag_idx_q [LATENCY];

  logic               gnt_vld;
  idx_t               gnt_idx;
  logic [IDX_W:0]     cand;

  // Search starts at ptr_q; in fixed-priority builds ptr_q never leaves 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (rst) begin
      gnt_vld = 1'b0;
    end
  end

  always_comb begin
`ifdef PIPE_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (gnt_idx == idx_t'(NUM_REQ-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = idx_t'(gnt_idx + 1'b1);
    end
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_vld) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      unit_in_q       <= '0;
      unit_in_valid_q <= 1'b0;
      issue_idx_q     <= '0;
    end else begin
      unit_in_valid_q <= gnt_vld;
      if (gnt_vld) begin
        unit_in_q   <= bus.req_data[gnt_idx*WIDTH +: WIDTH];
        issue_idx_q <= gnt_idx;
        ptr_q       <= ptr_d;
      end
    end
  end

  // Stage 0 sits one cycle behind unit_in, so the last stage lines up with unit_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      for (int s = LATENCY-1; s > 0; s--) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_idx_q[s]   <= tag_idx_q[s-1];
      end
      tag_valid_q[0] <= unit_in_valid_q;
      tag_idx_q[0]   <= issue_idx_q;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
    assign bus.resp_valid[i] = tag_valid_q[LATENCY-1] &&
                               (tag_idx_q[LATENCY-1] == idx_t'(i));
  end

  assign bus.resp_data     = bus.unit_out;
  assign bus.unit_in       = unit_in_q;
  assign bus.unit_in_valid = unit_in_valid_q;
  assign bus.busy          = unit_in_valid_q | (|tag_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_pipe_share_arbiter.sv
// +------------------------------------------------------------------+
// | tb_pipe_share_arbiter : vector-table bench for pipe_share_arbiter|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipe_share_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int WIDTH        = 32;
  localparam int RESULT_WIDTH = 32;
  localparam int LATENCY      = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_share_arbiter_if #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .RESULT_WIDTH(RESULT_WIDTH)
  ) bus ();

  pipe_share_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .RESULT_WIDTH(RESULT_WIDTH), .LATENCY(LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared unit: two unreset stages, result = operand + 0x1000
  logic [31:0] s0, s1;
  always_ff @(posedge clk) begin
    s0 <= bus.unit_in + 32'h1000;
    s1 <= s0;
  end
  assign bus.unit_out = s1;

  typedef struct packed {
    logic [3:0]  rv;
    logic [3:0]  rdy;
    logic        uiv;
    logic [31:0] uin;
    logic [3:0]  resp;
    logic [31:0] rdata;
    logic        busy;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_data(input int r);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data[i*WIDTH +: WIDTH] = 32'((r << 4) | i);
    end
  endtask

  logic [3:0] exp_c1;

  initial begin
    // Operand of requester i in row r is (r<<4)|i; result is operand + 0x1000.
`ifdef PIPE_ARB_FIXED_PRIO_EN
    tbl.push_back('{4'b0110, 4'b0010, 1'b0, 32'h00, 4'b0000, 32'h0,    1'b0});
    tbl.push_back('{4'b0110, 4'b0010, 1'b1, 32'h01, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b0110, 4'b0010, 1'b1, 32'h11, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b0110, 4'b0010, 1'b1, 32'h21, 4'b0010, 32'h1001, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 32'h31, 4'b0010, 32'h1011, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h31, 4'b0010, 32'h1021, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h31, 4'b0010, 32'h1031, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h31, 4'b0000, 32'h0,    1'b0});
    exp_c1 = 4'b0001;
`else
    tbl.push_back('{4'b1111, 4'b0001, 1'b0, 32'h000, 4'b0000, 32'h0,    1'b0}); // r0
    tbl.push_back('{4'b1111, 4'b0010, 1'b1, 32'h000, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b1111, 4'b0100, 1'b1, 32'h011, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b1111, 4'b1000, 1'b1, 32'h022, 4'b0001, 32'h1000, 1'b1});
    tbl.push_back('{4'b1111, 4'b0001, 1'b1, 32'h033, 4'b0010, 32'h1011, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 32'h040, 4'b0100, 32'h1022, 1'b1}); // r5
    tbl.push_back('{4'b0100, 4'b0100, 1'b0, 32'h040, 4'b1000, 32'h1033, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 32'h062, 4'b0001, 32'h1040, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h062, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b1001, 4'b1000, 1'b0, 32'h062, 4'b0100, 32'h1062, 1'b1});
    tbl.push_back('{4'b1001, 4'b0001, 1'b1, 32'h093, 4'b0000, 32'h0,    1'b1}); // r10
    tbl.push_back('{4'b1001, 4'b1000, 1'b1, 32'h0A0, 4'b0000, 32'h0,    1'b1});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 32'h0B3, 4'b1000, 32'h1093, 1'b1});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 32'h0C0, 4'b0001, 32'h10A0, 1'b1});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 32'h0D0, 4'b1000, 32'h10B3, 1'b1});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 32'h0E0, 4'b0001, 32'h10C0, 1'b1}); // r15
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 32'h0F0, 4'b0001, 32'h10D0, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 32'h100, 4'b0001, 32'h10E0, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h100, 4'b0001, 32'h10F0, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h100, 4'b0001, 32'h1100, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 32'h100, 4'b0000, 32'h0,    1'b0}); // r20
    exp_c1 = 4'b0010;
`endif

    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready",     32'(bus.req_ready), 32'h0);
    chk("reset unit_in_valid", 32'(bus.unit_in_valid), 32'h0);
    chk("reset unit_in",       bus.unit_in, 32'h0);
    chk("reset resp_valid",    32'(bus.resp_valid), 32'h0);
    chk("reset busy",          32'(bus.busy), 32'h0);
    rst = 1'b0;

    foreach (tbl[r]) begin
      bus.req_valid = tbl[r].rv;
      set_data(r);
      @(negedge clk);
      chk($sformatf("row%0d req_ready", r),     32'(bus.req_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d unit_in_valid", r), 32'(bus.unit_in_valid), 32'(tbl[r].uiv));
      chk($sformatf("row%0d unit_in", r),       bus.unit_in, tbl[r].uin);
      chk($sformatf("row%0d resp_valid", r),    32'(bus.resp_valid), 32'(tbl[r].resp));
      chk($sformatf("row%0d busy", r),          32'(bus.busy), 32'(tbl[r].busy));
      if (tbl[r].resp != 4'b0000) begin
        chk($sformatf("row%0d resp_data", r), bus.resp_data, tbl[r].rdata);
      end
      @(posedge clk);
      #1;
    end

    // Two operations in flight, then an asynchronous reset mid-cycle.
    bus.req_valid = 4'b0011;
    bus.req_data  = {32'h3, 32'h2, 32'h55, 32'h44};
    @(negedge clk);
    chk("mid c1 req_ready", 32'(bus.req_ready), 32'(exp_c1));
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("mid c2 req_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1001;
    #1;
    rst = 1'b1;
    #1;
    chk("async rst req_ready",     32'(bus.req_ready), 32'h0);
    chk("async rst unit_in_valid", 32'(bus.unit_in_valid), 32'h0);
    chk("async rst unit_in",       bus.unit_in, 32'h0);
    chk("async rst resp_valid",    32'(bus.resp_valid), 32'h0);
    chk("async rst busy",          32'(bus.busy), 32'h0);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2*LATENCY; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d resp_valid", c), 32'(bus.resp_valid), 32'h0);
      chk($sformatf("post-rst c%0d busy", c),       32'(bus.busy), 32'h0);
    end

    // Pointer must be back at 0: requester 0 beats requester 3.
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1001;
    bus.req_data  = {32'h0, 32'h0, 32'h0, 32'hAB};
    @(negedge clk);
    chk("post-rst grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post-rst resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("post-rst resp_data",  bus.resp_data, 32'h10AB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
